vga_sync_decoder: RTL and testbench

- Receive-side counterpart of the VGA timing generator.
- Samples an incoming hsync/vsync/blank_n stream on a pixel strobe and recovers the line length, the frame height and the active-pixel coordinates.
- Locks onto the timing, reports sticky timing errors, and gives capture/overlay logic and the verification harness a checked x/y position.
- All inputs are synchronous to clk, so no synchronizers are needed.

---
 rtl/vga_sync_decoder.sv | 167 ++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing checker: measures line/frame lengths, tracks the active
// window to produce x/y, and locks after a run of clean frames.
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       blank_n_in,
  input  logic       clr_err,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pix_valid,
  output logic       line_start,
  output logic       frame_start,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic       locked,
  output logic       err_hlen,
  output logic       err_vlen,
  output logic       err_act
);

  // state  | meaning
  // SEARCH | waiting for a vsync falling edge; nothing is checked
  // ALIGN  | every line/frame checked; counting clean frames toward lock
  // LOCKED | timing confirmed; same checks, any error drops back to SEARCH
  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  localparam logic [9:0] H_TOT   = 10'(H_TOTAL);
  localparam logic [9:0] V_TOT   = 10'(V_TOTAL);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [2:0] LOCK_N  = 3'(LOCK_FRAMES);
  localparam logic [9:0] CNT_MAX = 10'h3ff;

  state_t     state, state_next;
  logic       hs_prev, vs_prev, hs_fall, vs_fall;
  logic [9:0] hcnt, vcnt, act_cnt;
  logic [9:0] hcnt_inc, vcnt_inc, act_inc, y_inc, frame_meas, act_lines_meas;
  logic [2:0] good_frames, good_next;
  logic       skip_hlen, skip_next;
  logic       line_had_act, checking, set_hlen, set_vlen, set_act, any_err;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

  always_comb begin
    hs_fall        = pix_en & hs_prev & ~hsync_in;
    vs_fall        = pix_en & vs_prev & ~vsync_in;
    hcnt_inc       = sat_inc(hcnt);
    vcnt_inc       = sat_inc(vcnt);
    act_inc        = sat_inc(act_cnt);
    y_inc          = sat_inc(y);
    line_had_act   = (act_cnt != 10'd0);
    // a line ending on the vsync edge still belongs to the frame that is closing
    frame_meas     = hs_fall ? vcnt_inc : vcnt;
    act_lines_meas = (hs_fall & line_had_act) ? y_inc : y;
    checking       = (state != SEARCH);
    set_hlen       = checking & hs_fall & ~((state == ALIGN) & skip_hlen) & (hcnt_inc != H_TOT);
    set_vlen       = checking & vs_fall & (frame_meas != V_TOT);
    set_act        = checking & ((hs_fall & line_had_act & (act_cnt != H_ACT)) |
                                 (vs_fall & (act_lines_meas != V_ACT)));
    any_err        = set_hlen | set_vlen | set_act;
  end

  always_comb begin
    state_next = state;
    good_next  = good_frames;
    skip_next  = skip_hlen;
    case (state)
      SEARCH: begin
        if (vs_fall) begin
          state_next = ALIGN;
          good_next  = 3'd0;
          skip_next  = 1'b1;
        end
      end
      ALIGN: begin
        if (any_err) begin
          state_next = SEARCH;
        end else begin
          // the line running when ALIGN was entered started before our hcnt did
          if (hs_fall) skip_next = 1'b0;
          if (vs_fall) begin
            good_next = good_frames + 3'd1;
            if (good_next == LOCK_N) state_next = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (any_err) state_next = SEARCH;
      end
      default: state_next = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= SEARCH;
      good_frames <= 3'd0;
      skip_hlen   <= 1'b0;
      hs_prev     <= 1'b1;
      vs_prev     <= 1'b1;
      hcnt        <= 10'd0;
      vcnt        <= 10'd0;
      act_cnt     <= 10'd0;
      x           <= 10'd0;
      y           <= 10'd0;
      pix_valid   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      line_len    <= 10'd0;
      frame_lines <= 10'd0;
      locked      <= 1'b0;
      err_hlen    <= 1'b0;
      err_vlen    <= 1'b0;
      err_act     <= 1'b0;
    end else begin
      state       <= state_next;
      good_frames <= good_next;
      skip_hlen   <= skip_next;
      err_hlen    <= (err_hlen & ~clr_err) | set_hlen;
      err_vlen    <= (err_vlen & ~clr_err) | set_vlen;
      err_act     <= (err_act & ~clr_err) | set_act;
      if (pix_en) begin
        hs_prev     <= hsync_in;
        vs_prev     <= vsync_in;
        line_start  <= hs_fall;
        frame_start <= vs_fall;
        locked      <= (state_next == LOCKED);
        pix_valid   <= (state_next == LOCKED) & blank_n_in;
        if (hs_fall) begin
          line_len <= hcnt_inc;
          hcnt     <= 10'd0;
          x        <= 10'd0;
          act_cnt  <= {9'd0, blank_n_in};
        end else begin
          hcnt <= hcnt_inc;
          if (blank_n_in) begin
            x       <= act_cnt;
            act_cnt <= act_inc;
          end
        end
        if (vs_fall) begin
          frame_lines <= frame_meas;
          vcnt        <= 10'd0;
          y           <= 10'd0;
        end else if (hs_fall) begin
          vcnt <= vcnt_inc;
          if (line_had_act) y <= y_inc;
        end
      end else begin
        line_start  <= 1'b0;
        frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled-down raster (20x12, active 12x8); every
// strobe is compared against a distance/count based reference model.
module tb_vga_sync_decoder;
  localparam int HT = 20, VT = 12, HA = 12, VA = 8, LF = 2;
  localparam int HS_W = 3, ACT0 = 5;
  localparam logic [46:0] PULSES = 47'h30;

  logic clk = 1'b0, rst = 1'b0, pix_en = 1'b0;
  logic hsync_in = 1'b1, vsync_in = 1'b1, blank_n_in = 1'b0, clr_err = 1'b0;
  logic [9:0] x, y, line_len, frame_lines;
  logic pix_valid, line_start, frame_start, locked, err_hlen, err_vlen, err_act;

  vga_sync_decoder #(.H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
                     .LOCK_FRAMES(LF)) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .blank_n_in(blank_n_in), .clr_err(clr_err), .x(x), .y(y), .pix_valid(pix_valid),
    .line_start(line_start), .frame_start(frame_start), .line_len(line_len),
    .frame_lines(frame_lines), .locked(locked), .err_hlen(err_hlen), .err_vlen(err_vlen),
    .err_act(err_act));

  always #5 clk = ~clk;

  wire [46:0] dut_vec = {x, y, line_len, frame_lines, pix_valid, line_start, frame_start,
                         locked, err_hlen, err_vlen, err_act};

  int n_chk = 0, n_pass = 0;

  // reference model: lengths are distances between edge indices, modes are 0/1/2
  int m_n, m_last_hs, m_hs_since_vs, m_act_in_line, m_act_lines, m_mode, m_good;
  int m_x, m_y, m_len, m_flines;
  bit m_skip, m_hp, m_vp, m_pv, m_ls, m_fs, m_lk, m_eh, m_ev, m_ea;

  int min_len, xmax, ymax;
  bit hold_bad;
  logic [46:0] rst_vec;

  function automatic logic [46:0] mvec();
    return {10'(m_x), 10'(m_y), 10'(m_len), 10'(m_flines), m_pv, m_ls, m_fs, m_lk,
            m_eh, m_ev, m_ea};
  endfunction

  task automatic model_reset();
    m_n = 0; m_last_hs = -1; m_hs_since_vs = 0; m_act_in_line = 0; m_act_lines = 0;
    m_mode = 0; m_good = 0; m_skip = 0; m_hp = 1; m_vp = 1;
    m_x = 0; m_y = 0; m_len = 0; m_flines = 0;
    m_pv = 0; m_ls = 0; m_fs = 0; m_lk = 0; m_eh = 0; m_ev = 0; m_ea = 0;
  endtask

  task automatic model_step(input bit h, input bit v, input bit b, input bit c);
    bit hf, vf, herr, verr, aerr;
    int len, fl, ended, vact;
    hf = m_hp && !h;
    vf = m_vp && !v;
    m_hp = h; m_vp = v;
    len = m_n - m_last_hs;
    if (len > 1023) len = 1023;
    fl = m_hs_since_vs + (hf ? 1 : 0);
    if (fl > 1023) fl = 1023;
    ended = m_act_in_line;
    vact = m_act_lines + ((hf && ended > 0) ? 1 : 0);
    herr = hf && m_mode != 0 && !(m_mode == 1 && m_skip) && len != HT;
    aerr = m_mode != 0 && ((hf && ended != 0 && ended != HA) || (vf && vact != VA));
    verr = vf && m_mode != 0 && fl != VT;
    if (c) begin m_eh = 0; m_ev = 0; m_ea = 0; end
    m_eh |= herr; m_ev |= verr; m_ea |= aerr;
    if (m_mode == 0) begin
      if (vf) begin m_mode = 1; m_good = 0; m_skip = 1; end
    end else if (herr || verr || aerr) begin
      m_mode = 0;
    end else if (m_mode == 1) begin
      if (hf) m_skip = 0;
      if (vf) begin
        m_good++;
        if (m_good == LF) m_mode = 2;
      end
    end
    if (hf) begin
      m_len = len; m_last_hs = m_n; m_x = 0; m_act_in_line = b; m_hs_since_vs++;
      if (ended > 0) begin m_act_lines++; m_y++; end
    end else if (b) begin
      m_x = m_act_in_line; m_act_in_line++;
    end
    if (vf) begin m_flines = fl; m_hs_since_vs = 0; m_act_lines = 0; m_y = 0; end
    m_ls = hf; m_fs = vf;
    m_lk = (m_mode == 2);
    m_pv = m_lk && b;
    m_n++;
  endtask

  task automatic strobe(input bit h, input bit v, input bit b, input bit c);
    hsync_in = h; vsync_in = v; blank_n_in = b; clr_err = c; pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0; clr_err = 1'b0;
    model_step(h, v, b, c);
  endtask

  // one raster frame; bad_line gets bad_len strobes, vsync falls at vpos of line 9
  task automatic frame(input string nm, input int nlines, input int bad_line, input int bad_len,
                       input int vpos, input int gap_max, input int clr_line, input int rst_line);
    int len, g;
    bit h, v, b, c;
    logic [46:0] snap;
    for (int l = 0; l < nlines; l++) begin
      len = (l == bad_line) ? bad_len : HT;
      for (int p = 0; p < len; p++) begin
        if (l == rst_line && p == 6) begin
          rst = 1'b0; @(posedge clk); #1; rst = 1'b1;
          model_reset();
          rst_vec = dut_vec;
        end
        h = (p >= HS_W);
        v = !((l == 9 && p >= vpos) || l == 10 || (l == 11 && p < vpos));
        b = (l < VA) && (p >= ACT0) && (p < ACT0 + HA);
        c = (l == clr_line && p == 3);
        strobe(h, v, b, c);
        n_chk++;
        if (dut_vec === mvec()) n_pass++;
        else $display("FAIL %s model l=%0d p=%0d got=%h exp=%h", nm, l, p, dut_vec, mvec());
        if (line_start && int'(line_len) < min_len) min_len = int'(line_len);
        if (pix_valid && int'(x) > xmax) xmax = int'(x);
        if (pix_valid && int'(y) > ymax) ymax = int'(y);
        g = (p == 10 && gap_max > 1) ? gap_max : int'($urandom_range(gap_max, 1));
        snap = dut_vec & ~PULSES;
        repeat (g) @(posedge clk);
        #1;
        if (dut_vec !== snap) hold_bad = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    n_chk++;
    if (dut_vec === 47'd0) n_pass++;
    else $display("FAIL reset_outputs got=%h exp=0", dut_vec);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_nominal();
    frame("nominal", 12, -1, HT, 8, 1, -1, -1);
    n_chk++; if (locked === 1'b0) n_pass++; else $display("FAIL nominal_lock1 got=%b exp=0", locked);
    frame("nominal", 12, -1, HT, 8, 1, -1, -1);
    n_chk++; if (locked === 1'b0) n_pass++; else $display("FAIL nominal_lock2 got=%b exp=0", locked);
    xmax = -1; ymax = -1;
    frame("nominal", 12, -1, HT, 8, 1, -1, -1);
    n_chk++; if (locked === 1'b1) n_pass++; else $display("FAIL nominal_lock3 got=%b exp=1", locked);
    frame("nominal", 12, -1, HT, 8, 1, -1, -1);
    n_chk++; if (line_len === 10'(HT)) n_pass++; else $display("FAIL nominal_line_len got=%0d exp=%0d", line_len, HT);
    n_chk++; if (frame_lines === 10'(VT)) n_pass++; else $display("FAIL nominal_frame_lines got=%0d exp=%0d", frame_lines, VT);
    n_chk++; if (xmax == HA - 1 && ymax == VA - 1) n_pass++;
    else $display("FAIL nominal_xy_range got=%0d/%0d exp=%0d/%0d", xmax, ymax, HA - 1, VA - 1);
    n_chk++; if ({err_hlen, err_vlen, err_act} === 3'b000) n_pass++;
    else $display("FAIL nominal_errors got=%b exp=000", {err_hlen, err_vlen, err_act});
  endtask

  task automatic test_short_line();
    min_len = 1024;
    frame("short_line", 12, 3, HT - 1, 8, 1, -1, -1);
    n_chk++; if (min_len == HT - 1) n_pass++; else $display("FAIL short_line_len got=%0d exp=%0d", min_len, HT - 1);
    n_chk++; if ({locked, err_hlen, err_vlen} === 3'b010) n_pass++;
    else $display("FAIL short_line_flags got=%b exp=010", {locked, err_hlen, err_vlen});
    frame("short_line", 12, -1, HT, 8, 1, -1, -1);
    n_chk++; if (locked === 1'b0) n_pass++; else $display("FAIL short_line_relock1 got=%b exp=0", locked);
    frame("short_line", 12, -1, HT, 8, 1, -1, -1);
    n_chk++; if ({locked, err_hlen} === 2'b11) n_pass++;
    else $display("FAIL short_line_relock2 got=%b exp=11", {locked, err_hlen});
    frame("short_line", 12, -1, HT, 8, 1, 0, -1);
    n_chk++; if (err_hlen === 1'b0) n_pass++; else $display("FAIL short_line_clr got=%b exp=0", err_hlen);
  endtask

  task automatic test_short_frame();
    frame("short_frame", VT - 1, -1, HT, 8, 1, -1, -1);
    frame("short_frame", 12, -1, HT, 8, 1, -1, -1);
    n_chk++; if (frame_lines === 10'(VT - 1)) n_pass++; else $display("FAIL short_frame_lines got=%0d exp=%0d", frame_lines, VT - 1);
    n_chk++; if ({locked, err_hlen, err_vlen, err_act} === 4'b0010) n_pass++;
    else $display("FAIL short_frame_flags got=%b exp=0010", {locked, err_hlen, err_vlen, err_act});
    frame("short_frame", 12, -1, HT, 8, 1, 1, -1);
    frame("short_frame", 12, -1, HT, 8, 1, -1, -1);
    frame("short_frame", 12, -1, HT, 8, 1, -1, -1);
    n_chk++; if ({locked, err_vlen} === 2'b10) n_pass++;
    else $display("FAIL short_frame_relock got=%b exp=10", {locked, err_vlen});
  endtask

  task automatic test_coincident();
    frame("coincident", 12, -1, HT, 0, 1, -1, -1);
    frame("coincident", 12, -1, HT, 0, 1, -1, -1);
    n_chk++; if (frame_lines === 10'(VT)) n_pass++; else $display("FAIL coincident_lines got=%0d exp=%0d", frame_lines, VT);
    n_chk++; if ({locked, err_hlen, err_vlen, err_act} === 4'b1000) n_pass++;
    else $display("FAIL coincident_flags got=%b exp=1000", {locked, err_hlen, err_vlen, err_act});
    frame("coincident", 12, -1, HT, 8, 1, -1, -1);
    n_chk++; if (frame_lines === 10'(VT)) n_pass++; else $display("FAIL coincident_restart got=%0d exp=%0d", frame_lines, VT);
  endtask

  task automatic test_gaps();
    hold_bad = 1'b0;
    frame("gaps", 12, -1, HT, 8, 3, -1, -1);
    frame("gaps", 12, -1, HT, 8, 3, -1, -1);
    n_chk++; if (hold_bad == 1'b0) n_pass++; else $display("FAIL gaps_hold got=changed exp=held");
    n_chk++; if (line_len === 10'(HT)) n_pass++; else $display("FAIL gaps_line_len got=%0d exp=%0d", line_len, HT);
    n_chk++; if ({locked, err_hlen, err_vlen, err_act} === 4'b1000) n_pass++;
    else $display("FAIL gaps_flags got=%b exp=1000", {locked, err_hlen, err_vlen, err_act});
  endtask

  task automatic test_reset_mid();
    frame("reset_mid", 12, -1, HT, 8, 1, -1, 4);
    n_chk++; if (rst_vec === 47'd0) n_pass++; else $display("FAIL reset_mid_outputs got=%h exp=0", rst_vec);
    n_chk++; if (locked === 1'b0) n_pass++; else $display("FAIL reset_mid_lock1 got=%b exp=0", locked);
    frame("reset_mid", 12, -1, HT, 8, 1, -1, -1);
    n_chk++; if (locked === 1'b0) n_pass++; else $display("FAIL reset_mid_lock2 got=%b exp=0", locked);
    frame("reset_mid", 12, -1, HT, 8, 1, -1, -1);
    n_chk++; if (locked === 1'b1) n_pass++; else $display("FAIL reset_mid_lock3 got=%b exp=1", locked);
  endtask

  task automatic test_random();
    int t, nl, bl, blen, vp, cl;
    for (int f = 0; f < 12; f++) begin
      t = int'($urandom_range(4, 0));
      nl = 12; bl = -1; blen = HT; vp = 8; cl = -1;
      case (t)
        1: begin bl = int'($urandom_range(11, 0)); blen = int'($urandom_range(23, 14)); end
        2: nl = int'($urandom_range(13, 11));
        3: vp = int'($urandom_range(15, 0));
        4: cl = int'($urandom_range(11, 0));
        default: ;
      endcase
      frame("random", nl, bl, blen, vp, 2, cl, -1);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_nominal();
    test_short_line();
    test_short_frame();
    test_coincident();
    test_gaps();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
